viterbi_decoder_k7: RTL and testbench
=====================================

Name: viterbi_decoder_k7

Overview:
- Frame-based hard-decision Viterbi decoder for the 802.11a rate-1/2 mother code: K=7, generators g0=133 octal and g1=171 octal.
- Sits after the deinterleaver/depuncturer in the receiver chain and feeds the descrambler.
- Relative to the first-generation decoder it adds: parametrised frame length and metric width; per-bit erasure inputs, so depunctured rates 2/3 and 3/4 decode correctly; full add-compare-select and traceback; terminated/unterminated mode; ready/valid handshakes on both sides.

Parameters:
- MAX_LEN, 288, maximum decoded bits per frame (sizes the survivor memory, 64 x MAX_LEN bits).
- METRIC_W, 8, path-metric width in bits, minimum 5.
- CNT_W, 9, frame counter width; must satisfy 2^CNT_W > MAX_LEN.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- InValid  in  1  received coded pair is valid
- InReady  out  1  decoder accepts a pair this cycle
- InA  in  1  received bit for g0
- InB  in  1  received bit for g1
- EraseA  in  1  InA is a punctured position; contributes 0 to the metric
- EraseB  in  1  InB is a punctured position
- InLast  in  1  qualifies the final pair of the frame
- Terminated  in  1  sampled with the first pair; 1 = traceback from state 0, 0 = traceback from the minimum-metric state
- OutValid  out  1  decoded bit valid
- OutReady  in  1  downstream accepts the decoded bit
- Output  out  1  decoded bit, in original order
- OutLast  out  1  marks the final decoded bit
- Overflow  out  1  frame was truncated at MAX_LEN; held until the next frame's first pair

Behaviour:
- Reset (Reset=0, asynchronous):
  - State goes to IDLE.
  - InReady=0, OutValid=0, Output=0, OutLast=0, Overflow=0.
  - Metric[0]=0; all other metrics = 2^METRIC_W-1; counter=0.
  - Reset mid-frame aborts the frame; no partial output is emitted.
- State convention:
  - s[5:0] holds the previous six input bits, s[5] most recent.
  - Expected outputs: A=u^s[4]^s[3]^s[1]^s[0], B=u^s[5]^s[4]^s[3]^s[0].
  - Next state = {u, s[5:1]}.
  - Predecessors of state n are {n[4:0],0} and {n[4:0],1}; u=n[5].
- Branch metric: (EraseA ? 0 : InA^A) + (EraseB ? 0 : InB^B), range 0..2.
- FSM:
  - IDLE: InReady=1. The first handshake (InValid & InReady) performs ACS step 0, latches Terminated, clears Overflow, then moves to ACS.
  - ACS: InReady=1. One trellis step per handshake; all 64 states are updated in the same cycle.
    - New metric = min over both predecessors of (pred metric + branch metric), saturating at 2^METRIC_W-1.
    - Tie selects the predecessor with LSB 0.
    - The decision bit (predecessor LSB) is stored in survivor column [counter], and counter increments.
    - The handshake with InLast=1, or the handshake that makes counter==MAX_LEN, moves to SELECT with InReady=0. The MAX_LEN case sets Overflow.
    - Cycles with InValid=0 leave all state unchanged.
  - Normalisation: after a step, if every new metric has its MSB set, the MSB of all 64 is cleared in the same cycle. The saturated value 2^METRIC_W-1 counts as MSB set.
  - SELECT:
    - Terminated=1: start state = 0, 1 cycle.
    - Terminated=0: sequential scan of states 0..63, 64 cycles. Strict less-than, so the lowest index wins ties.
  - TRCBK: one cycle per step, for counter steps from column counter-1 down to 0.
    - Decoded bit = cur[5], written to bit buffer [column].
    - cur <= {cur[4:0], decision[column][cur]}.
  - EMIT: presents bit buffer [0..counter-1] in order.
    - Output/OutValid are held stable until OutReady; the index advances only on OutValid & OutReady.
    - OutLast=1 with the final bit; after that handshake go to IDLE.
    - Reset values are re-applied to metrics and counter on IDLE entry.
- Latency, frame of N pairs: N accept cycles; SELECT (1 or 64 cycles); N TRCBK cycles; then first OutValid.
- InReady is 0 in SELECT, TRCBK and EMIT, so no new frame overlaps the current one.
- A single-pair frame (InLast on the first handshake) is legal and emits 1 bit.

Test Plan:
- Encode 24 bits 0x5A3C00 (last 6 zero tail) at rate 1/2, Terminated=1, no errors -> 24 outputs equal 0x5A3C00 MSB-first, OutLast on bit 24, Overflow=0.
- Same frame with 3 channel bit flips at pair indices 2, 9, 17 -> output still equals 0x5A3C00.
- Same frame punctured to rate 3/4 (erase B of pair 1, A of pair 2 per period of 3 pairs), erased bits driven with random values -> output equals 0x5A3C00.
- All-ones 40-bit unterminated frame, Terminated=0 -> 40 ones, and the selected end state is 63.
- OutReady toggled 1-0-0-1 pseudo-randomly through EMIT -> Output stable while stalled, no bit lost or duplicated. Reset asserted at pair 10 of a frame -> OutValid=0, InReady=0 immediately, InReady=1 after release, and the next frame decodes correctly.
- MAX_LEN=16 build, 20 pairs sent -> InReady drops after pair 16, Overflow=1, 16 bits emitted.

Source files
------------

// File: rtl/viterbi_decoder_k7.sv
// viterbi_decoder_k7: frame-based hard-decision K=7 (133/171) Viterbi decoder with erasures,
// full-parallel ACS, survivor traceback and ready/valid handshakes on both sides.
module viterbi_decoder_k7 #(
    parameter int MAX_LEN  = 288,
    parameter int METRIC_W = 8,
    parameter int CNT_W    = 9
) (
    input  logic Clock,
    input  logic Reset,
    input  logic InValid,
    output logic InReady,
    input  logic InA,
    input  logic InB,
    input  logic EraseA,
    input  logic EraseB,
    input  logic InLast,
    input  logic Terminated,
    output logic OutValid,
    input  logic OutReady,
    output logic Output,
    output logic OutLast,
    output logic Overflow
);
    localparam logic [2:0] IDLE = 3'd0, ACS = 3'd1, SELECT = 3'd2, TRCBK = 3'd3, EMIT = 3'd4;
    localparam logic [METRIC_W-1:0] MAX_M = '1;
    localparam logic [CNT_W-1:0] LEN_END = CNT_W'(MAX_LEN);

    logic [2:0] state;
    logic armed, term, accept, all_msb, len_hit;
    logic [METRIC_W-1:0] metric [64];
    logic [METRIC_W-1:0] new_m [64];
    logic [METRIC_W-1:0] c0 [64];
    logic [METRIC_W-1:0] c1 [64];
    logic [63:0] dec;
    logic [63:0] surv [MAX_LEN];
    logic [MAX_LEN-1:0] bit_buf;
    logic [CNT_W-1:0] cnt, ptr;
    logic [5:0] idx, best_s, cur;
    logic [METRIC_W-1:0] best_m;

    function automatic logic [1:0] brm(input logic [5:0] p, input logic u, input logic a, b, xa, xb);
        logic da, db;
        da = ~xa & (a ^ u ^ p[4] ^ p[3] ^ p[1] ^ p[0]);
        db = ~xb & (b ^ u ^ p[5] ^ p[4] ^ p[3] ^ p[0]);
        return {1'b0, da} + {1'b0, db};
    endfunction

    function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] m, input logic [1:0] b);
        logic [METRIC_W:0] s;
        s = {1'b0, m} + {{(METRIC_W-1){1'b0}}, b};
        return s[METRIC_W] ? MAX_M : s[METRIC_W-1:0];
    endfunction

    assign InReady  = armed & (state == IDLE || state == ACS);
    assign accept   = InValid & InReady;
    assign len_hit  = (cnt + 1'b1) == LEN_END;
    assign OutValid = state == EMIT;
    assign Output   = OutValid & bit_buf[ptr];
    assign OutLast  = OutValid & (ptr == cnt - 1'b1);

    // Predecessors of n are {n[4:0],0} and {n[4:0],1}; ties keep the LSB-0 branch.
    always_comb begin
        all_msb = 1'b1;
        dec = '0;
        for (int n = 0; n < 64; n++) begin
            c0[n] = sat_add(metric[{n[4:0], 1'b0}], brm({n[4:0], 1'b0}, n[5], InA, InB, EraseA, EraseB));
            c1[n] = sat_add(metric[{n[4:0], 1'b1}], brm({n[4:0], 1'b1}, n[5], InA, InB, EraseA, EraseB));
            dec[n] = c1[n] < c0[n];
            new_m[n] = dec[n] ? c1[n] : c0[n];
            all_msb &= new_m[n][METRIC_W-1];
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            armed    <= 1'b0;
            term     <= 1'b0;
            Overflow <= 1'b0;
            cnt      <= '0;
            ptr      <= '0;
            idx      <= '0;
            best_s   <= '0;
            best_m   <= '0;
            cur      <= '0;
            for (int n = 0; n < 64; n++) metric[n] <= (n == 0) ? '0 : MAX_M;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE, ACS: if (accept) begin
                    for (int n = 0; n < 64; n++)
                        metric[n] <= all_msb ? {1'b0, new_m[n][METRIC_W-2:0]} : new_m[n];
                    cnt      <= cnt + 1'b1;
                    ptr      <= cnt;
                    idx      <= '0;
                    term     <= (state == IDLE) ? Terminated : term;
                    Overflow <= ~InLast & len_hit;
                    state    <= (InLast | len_hit) ? SELECT : ACS;
                end
                SELECT: if (term) begin
                    cur   <= '0;
                    state <= TRCBK;
                end else begin
                    idx <= idx + 1'b1;
                    if (idx == 6'd0 || metric[idx] < best_m) begin
                        best_m <= metric[idx];
                        best_s <= idx;
                    end
                    if (idx == 6'd63) begin
                        cur   <= (metric[63] < best_m) ? 6'd63 : best_s;
                        state <= TRCBK;
                    end
                end
                TRCBK: begin
                    cur   <= {cur[4:0], surv[ptr][cur]};
                    ptr   <= (ptr == '0) ? '0 : ptr - 1'b1;
                    state <= (ptr == '0) ? EMIT : TRCBK;
                end
                EMIT: if (OutReady) begin
                    ptr <= ptr + 1'b1;
                    if (OutLast) begin
                        state <= IDLE;
                        cnt   <= '0;
                        ptr   <= '0;
                        for (int n = 0; n < 64; n++) metric[n] <= (n == 0) ? '0 : MAX_M;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (accept) surv[cnt] <= dec;
        if (state == TRCBK) bit_buf[ptr] <= cur[5];
    end
endmodule

// File: tb/tb_viterbi_decoder_k7.sv
// tb_viterbi_decoder_k7: table-driven frame tests with an encoder model and an expected-bit scoreboard.
module tb_viterbi_decoder_k7;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [1:0] inv = '0, ina = '0, inb = '0, ea = '0, eb = '0, il = '0, tm = '0, ordy = '0;
    logic [1:0] ir, ov, od, ol, of;

    always #5 clk = ~clk;

    viterbi_decoder_k7 dut (
        .Clock(clk), .Reset(rst_n), .InValid(inv[0]), .InReady(ir[0]), .InA(ina[0]), .InB(inb[0]),
        .EraseA(ea[0]), .EraseB(eb[0]), .InLast(il[0]), .Terminated(tm[0]), .OutValid(ov[0]),
        .OutReady(ordy[0]), .Output(od[0]), .OutLast(ol[0]), .Overflow(of[0])
    );

    viterbi_decoder_k7 #(.MAX_LEN(16), .CNT_W(5)) dut16 (
        .Clock(clk), .Reset(rst_n), .InValid(inv[1]), .InReady(ir[1]), .InA(ina[1]), .InB(inb[1]),
        .EraseA(ea[1]), .EraseB(eb[1]), .InLast(il[1]), .Terminated(tm[1]), .OutValid(ov[1]),
        .OutReady(ordy[1]), .Output(od[1]), .OutLast(ol[1]), .Overflow(of[1])
    );

    typedef struct {
        logic [63:0] bits;
        int          len;
        logic        term;
        logic [63:0] fa;
        logic [63:0] fb;
        bit          punct;
        bit          stall;
        logic [63:0] want;
        logic        ovf;
    } case_t;

    int tests = 0, fails = 0;
    bit exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // Encodes and sends pairs; pushes the expected decoded bit of every accepted pair.
    task automatic send_frame(input int k, input logic [63:0] bits, input logic [63:0] want, input int len,
                              input logic term, input logic [63:0] fa, input logic [63:0] fb,
                              input bit punct, input int abort_at, output int acc_cnt);
        logic [5:0] s;
        logic u, a, b, xa, xb;
        bit acc;
        s = '0;
        acc_cnt = 0;
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) return;
            u = bits[len-1-i];
            a = u ^ s[4] ^ s[3] ^ s[1] ^ s[0] ^ fa[i];
            b = u ^ s[5] ^ s[4] ^ s[3] ^ s[0] ^ fb[i];
            s = {u, s[5:1]};
            xa = punct && (i % 3 == 2);
            xb = punct && (i % 3 == 1);
            if (xa) a = 1'($urandom);
            if (xb) b = 1'($urandom);
            acc = 0;
            for (int t = 0; t < 8 && !acc; t++) begin
                @(negedge clk);
                inv[k] = 1'b1; ina[k] = a; inb[k] = b; ea[k] = xa; eb[k] = xb;
                il[k] = (i == len - 1); tm[k] = term;
                acc = ir[k];
                @(posedge clk);
            end
            if (!acc) return;
            exp_q.push_back(want[len-1-i]);
            acc_cnt++;
        end
    endtask

    task automatic collect(input int k, input bit stall, input int lat);
        int c, nout;
        bit done, held, seen;
        logic hv, want;
        c = 0; nout = 0; done = 0; held = 0; seen = 0; hv = 0;
        while (!done && c < 3000) begin
            @(negedge clk);
            c++;
            inv[k] = 1'b0;
            ordy[k] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ov[k]) begin
                if (!seen && lat > 0) chk("latency", 64'(c), 64'(lat));
                seen = 1;
                if (held) chk("stall_hold", od[k], hv);
                if (ordy[k]) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_bit", 64'(nout), 64'(nout - 1));
                        done = 1;
                    end else begin
                        want = exp_q.pop_front();
                        chk($sformatf("bit%0d", nout), od[k], want);
                        chk($sformatf("last%0d", nout), ol[k], exp_q.size() == 0);
                        nout++;
                        held = 0;
                        done = ol[k];
                    end
                end else begin
                    held = 1;
                    hv = od[k];
                end
            end
            @(posedge clk);
        end
        chk("frame_done", done, 1);
        chk("drained", exp_q.size(), 0);
        exp_q.delete();
        ordy[k] = 1'b1;
    endtask

    initial begin
        case_t cs[7];
        int acc;
        cs[0] = '{64'h5A3C00, 24, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0, 64'h5A3C00, 1'b0};
        cs[1] = '{64'h5A3C00, 24, 1'b1, 64'h20004, 64'h200, 1'b0, 1'b0, 64'h5A3C00, 1'b0};
        cs[2] = '{64'h5A3C00, 24, 1'b1, 64'h0, 64'h0, 1'b1, 1'b0, 64'h5A3C00, 1'b0};
        cs[3] = '{64'hFF_FFFF_FFFF, 40, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'hFF_FFFF_FFFF, 1'b0};
        cs[4] = '{64'h5A3C00, 24, 1'b1, 64'h0, 64'h0, 1'b0, 1'b1, 64'h5A3C00, 1'b0};
        cs[5] = '{64'h1, 1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h1, 1'b0};
        cs[6] = '{64'hC3A59600, 32, 1'b1, 64'h0, 64'h0, 1'b0, 1'b1, 64'hC3A59600, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_ready", ir, 2'b00);
        chk("rst_valid", ov, 2'b00);
        chk("rst_output", od, 2'b00);
        chk("rst_last", ol, 2'b00);
        chk("rst_overflow", of, 2'b00);
        rst_n = 1'b1;
        ordy = 2'b11;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_rst", ir, 2'b11);

        for (int i = 0; i < 7; i++) begin
            send_frame(0, cs[i].bits, cs[i].want, cs[i].len, cs[i].term, cs[i].fa, cs[i].fb,
                       cs[i].punct, -1, acc);
            chk($sformatf("accepted_c%0d", i), 64'(acc), 64'(cs[i].len));
            collect(0, cs[i].stall, cs[i].len + (cs[i].term ? 1 : 64) + 1);
            @(negedge clk);
            chk($sformatf("overflow_c%0d", i), of[0], cs[i].ovf);
            chk($sformatf("idle_c%0d", i), {ov[0], ir[0]}, 2'b01);
        end

        // Reset at pair 10 aborts the frame; the next frame must still decode.
        send_frame(0, cs[0].bits, cs[0].want, cs[0].len, 1'b1, 64'h0, 64'h0, 1'b0, 10, acc);
        chk("abort_accepted", 64'(acc), 64'd10);
        @(negedge clk);
        inv = '0;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", ov[0], 1'b0);
        chk("abort_ready", ir[0], 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ready_after", ir[0], 1'b1);
        send_frame(0, cs[0].bits, cs[0].want, cs[0].len, 1'b1, 64'h0, 64'h0, 1'b0, -1, acc);
        collect(0, 1'b0, cs[0].len + 2);

        // Truncation on the MAX_LEN=16 build: 20 pairs offered, first 16 decoded.
        send_frame(1, 64'hABCDE, 64'hABCDE, 20, 1'b0, 64'h0, 64'h0, 1'b0, -1, acc);
        chk("ovf_accepted", 64'(acc), 64'd16);
        collect(1, 1'b0, 0);
        @(negedge clk);
        chk("ovf_flag", of[1], 1'b1);
        chk("ovf_idle", {ov[1], ir[1]}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
